// File: rtl/cache_mem_responder_if.sv
`default_nettype none
// ============================================================================
// cache_mem_responder_if
// Request/response bus between the cache refill path and the backing memory.
// Revision: 1.0
// ============================================================================
interface cache_mem_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic                  resp_valid_o;
  logic                  resp_ready_i;
  logic [DATA_WIDTH-1:0] resp_data_o;
  logic                  resp_last_o;
  logic                  busy_o;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_data_o, resp_last_o, busy_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_data_o, resp_last_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/cache_mem_responder.sv
`default_nettype none
// ============================================================================
// cache_mem_responder
// Backing memory for cache refills: single-word writes, fixed-latency line
// reads returned as a beat burst. Define CACHE_MEM_CRITICAL_WORD_FIRST_EN to
// start each burst at the requested word.
// Revision: 1.0
// ============================================================================
module cache_mem_responder #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MEM_DEPTH_LOG2  = 10,
  parameter int LINE_WORDS_LOG2 = 2,
  parameter int LATENCY         = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cache_mem_responder_if.slave   bus
);

  localparam int MEM_DEPTH = 1 << MEM_DEPTH_LOG2;
  localparam int BEAT_W    = (LINE_WORDS_LOG2 > 0) ? LINE_WORDS_LOG2 : 1;
  localparam int CNT_W     = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  localparam logic [MEM_DEPTH_LOG2-1:0] LINE_MASK = MEM_DEPTH_LOG2'((1 << LINE_WORDS_LOG2) - 1);
  localparam logic [BEAT_W-1:0]         LAST_BEAT = BEAT_W'((1 << LINE_WORDS_LOG2) - 1);
  localparam logic [CNT_W-1:0]          LAT_LOAD  = CNT_W'(LATENCY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [MEM_DEPTH_LOG2-1:0] base_q, base_d;
  logic [MEM_DEPTH_LOG2-1:0] start_q, start_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic [CNT_W-1:0]          wait_q, wait_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;

  logic [DATA_WIDTH-1:0]     mem [MEM_DEPTH];

  logic [MEM_DEPTH_LOG2-1:0] req_idx;
  logic [MEM_DEPTH_LOG2-1:0] req_start;
  logic                      req_fire;
  logic                      beat_fire;
  logic                      wr_en;
  logic                      unused_addr;

  assign req_idx     = bus.req_addr_i[MEM_DEPTH_LOG2+1:2];
  assign unused_addr = ^bus.req_addr_i;
  assign req_fire    = bus.req_valid_i && (state_q == IDLE);
  assign beat_fire   = (state_q == BURST) && bus.resp_ready_i;
  assign wr_en       = req_fire && bus.req_we_i && rst_n;

`ifdef CACHE_MEM_CRITICAL_WORD_FIRST_EN
  assign req_start = req_idx & LINE_MASK;
`else
  assign req_start = '0;
`endif

  // Word of the line delivered on a given beat; wraps inside the line.
  function automatic logic [MEM_DEPTH_LOG2-1:0] word_idx(
    input logic [MEM_DEPTH_LOG2-1:0] base,
    input logic [MEM_DEPTH_LOG2-1:0] start,
    input logic [BEAT_W-1:0]         beat
  );
    return base | ((start + MEM_DEPTH_LOG2'(beat)) & LINE_MASK);
  endfunction

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    start_d = start_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (req_fire && !bus.req_we_i) begin
          base_d  = req_idx & ~LINE_MASK;
          start_d = req_start;
          beat_d  = '0;
          wait_d  = LAT_LOAD;
          if (LATENCY == 0) begin
            state_d = BURST;
            data_d  = mem[word_idx(req_idx & ~LINE_MASK, req_start, '0)];
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // The count reaching zero coincides with the first beat being loaded.
        if (wait_q <= CNT_W'(1)) begin
          wait_d  = '0;
          state_d = BURST;
          data_d  = mem[word_idx(base_q, start_q, '0)];
        end else begin
          wait_d = wait_q - CNT_W'(1);
        end
      end
      BURST: begin
        if (beat_fire) begin
          if (beat_q == LAST_BEAT) begin
            state_d = IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
            data_d = mem[word_idx(base_q, start_q, beat_q + BEAT_W'(1))];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      start_q <= '0;
      beat_q  <= '0;
      wait_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      start_q <= start_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      data_q  <= data_d;
    end
  end

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[req_idx] <= bus.req_wdata_i;
    end
  end

  assign bus.req_ready_o  = (state_q == IDLE);
  assign bus.resp_valid_o = (state_q == BURST);
  assign bus.resp_last_o  = (state_q == BURST) && (beat_q == LAST_BEAT);
  assign bus.resp_data_o  = data_q;
  assign bus.busy_o       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_responder.sv
`default_nettype none
// ============================================================================
// tb_cache_mem_responder
// Randomized bench for cache_mem_responder against an array-based memory model.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_cache_mem_responder;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int MDL  = 10;
  localparam int LWL2 = 2;
  localparam int LAT  = 4;
  localparam int LW   = 1 << LWL2;
  localparam int DEPTH = 1 << MDL;
`ifdef CACHE_MEM_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_mem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  cache_mem_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH_LOG2(MDL),
    .LINE_WORDS_LOG2(LWL2), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  logic [DW-1:0] mdl [DEPTH];
  int n_cmp = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory word returned on beat b of a line read to addr.
  function automatic int exp_idx(input logic [AW-1:0] addr, input int b);
    int w, base, start;
    w     = int'(addr[MDL+1:2]);
    base  = w - (w % LW);
    start = CWF ? (w % LW) : 0;
    return base + ((start + b) % LW);
  endfunction

  task automatic check_idle_reset(input string name);
    logic [DW+3:0] obs, expv;
    obs  = {bus.req_ready_o, bus.resp_valid_o, bus.resp_last_o, bus.busy_o, bus.resp_data_o};
    expv = {1'b1, 1'b0, 1'b0, 1'b0, {DW{1'b0}}};
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: {ready,valid,last,busy,data} got %h expected %h", name, obs, expv);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b1;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = data;
    n_cmp++;
    if (bus.req_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL write_ready: got %b expected 1", bus.req_ready_o);
    end
    tick();
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
    mdl[addr[MDL+1:2]] = data;
  endtask

  task automatic accept_read(input logic [AW-1:0] addr);
    int t;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = addr;
    t = 0;
    while (bus.req_ready_o !== 1'b1 && t < 100) begin
      tick();
      t++;
    end
    n_cmp++;
    if (t >= 100) begin
      n_err++;
      $display("FAIL read_accept_timeout: ready got %b expected 1", bus.req_ready_o);
    end
    tick();
    bus.req_valid_i = 1'b0;
  endtask

  // Called right after the acceptance edge; checks latency, beats and return to idle.
  task automatic burst_check(input logic [AW-1:0] addr, input int stall_beat,
                             input int stall_cyc, input bit rnd);
    logic [DW+2:0] obs, expv;
    int s;
    for (int k = 0; k < LAT; k++) begin
      n_cmp++;
      if ({bus.resp_valid_o, bus.busy_o, bus.req_ready_o} !== 3'b010) begin
        n_err++;
        $display("FAIL latency_wait%0d: {valid,busy,ready} got %b expected 010",
                 k, {bus.resp_valid_o, bus.busy_o, bus.req_ready_o});
      end
      tick();
    end
    for (int b = 0; b < LW; b++) begin
      s = rnd ? int'($urandom_range(0, 2)) : ((b == stall_beat) ? stall_cyc : 0);
      expv = {1'b1, (b == LW - 1), 1'b0, mdl[exp_idx(addr, b)]};
      for (int j = 0; j <= s; j++) begin
        bus.resp_ready_i = (j == s);
        obs = {bus.resp_valid_o, bus.resp_last_o, bus.req_ready_o, bus.resp_data_o};
        n_cmp++;
        if (obs !== expv) begin
          n_err++;
          $display("FAIL beat%0d_cyc%0d addr %h: {valid,last,ready,data} got %h expected %h",
                   b, j, addr, obs, expv);
        end
        tick();
      end
    end
    bus.resp_ready_i = 1'b1;
    n_cmp++;
    if ({bus.req_ready_o, bus.busy_o, bus.resp_valid_o} !== 3'b100) begin
      n_err++;
      $display("FAIL burst_end: {ready,busy,valid} got %b expected 100",
               {bus.req_ready_o, bus.busy_o, bus.resp_valid_o});
    end
  endtask

  task automatic test_reset();
    check_idle_reset("reset_powerup");
    accept_read(32'h0000_0040);
    for (int i = 0; i < LAT + 2; i++) tick();
    bus.resp_ready_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check_idle_reset("reset_mid_burst_async");
    tick();
    rst_n = 1'b1;
    tick();
    check_idle_reset("reset_mid_burst_release");
    bus.resp_ready_i = 1'b1;
  endtask

  task automatic test_fill();
    logic [AW-1:0] a;
    for (int i = 0; i < DEPTH; i++) begin
      a = ($urandom & ~32'h0000_0FFC) | (i << 2);
      do_write(a, $urandom);
    end
  endtask

  task automatic test_write_read();
    do_write(32'h0000_0010, 32'hDEAD_BEEF);
    accept_read(32'h0000_0010);
    burst_check(32'h0000_0010, -1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    accept_read(32'h0000_0010);
    burst_check(32'h0000_0010, 1, 3, 1'b0);
  endtask

  task automatic test_word_order();
    for (int i = 0; i < 4; i++) do_write(32'h10 + 32'(i * 4), 32'(i + 1));
    accept_read(32'h0000_0018);
    burst_check(32'h0000_0018, -1, 0, 1'b0);
    do_write(32'h0000_0010, 32'hDEAD_BEEF);
  endtask

  task automatic test_reset_mid_wait();
    accept_read(32'h0000_0010);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_idle_reset("reset_mid_wait_async");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 3; i++) begin
      n_cmp++;
      if (bus.resp_valid_o !== 1'b0) begin
        n_err++;
        $display("FAIL post_reset_no_valid%0d: got %b expected 0", i, bus.resp_valid_o);
      end
      tick();
    end
    accept_read(32'h0000_0010);
    burst_check(32'h0000_0010, -1, 0, 1'b0);
  endtask

  task automatic test_held_request();
    accept_read(32'h0000_0104);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = 32'hF000_022C;
    burst_check(32'h0000_0104, 2, 2, 1'b0);
    tick();
    bus.req_valid_i = 1'b0;
    burst_check(32'hF000_022C, -1, 0, 1'b1);
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      if ($urandom_range(0, 9) < 4) begin
        do_write(a, $urandom);
      end else begin
        accept_read(a);
        burst_check(a, -1, 0, 1'b1);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n            = 1'b0;
    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'b0;
    bus.req_addr_i   = '0;
    bus.req_wdata_i  = '0;
    bus.resp_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_fill();
    test_write_read();
    test_backpressure();
    test_word_order();
    test_reset_mid_wait();
    test_held_request();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
